// File: rtl/simmem_pkg.sv
// Channel types and sizing shared by the simulated-memory responder and its queues.
package simmem_pkg;

  localparam int unsigned IdW               = 6;
  localparam int unsigned AddrW             = 32;
  localparam int unsigned DataW             = 32;
  localparam int unsigned MaxBurstLenFieldW = 4;

  localparam int unsigned WAddrQueueDepth = 4;
  localparam int unsigned RAddrQueueDepth = 4;

  typedef struct packed {
    logic [IdW-1:0]               id;
    logic [AddrW-1:0]             addr;
    logic [MaxBurstLenFieldW-1:0] burst_len;
  } waddr_t;

  typedef waddr_t raddr_t;

  typedef struct packed {
    logic [DataW-1:0] data;
  } wdata_t;

  typedef struct packed {
    logic [IdW-1:0] id;
  } wrsp_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic             last;
  } rdata_t;

  typedef enum logic {
    RdIdle  = 1'b0,
    RdBurst = 1'b1
  } rd_state_e;

endpackage

// File: rtl/simmem_resp_fifo.sv
// Registered FIFO with wrap-bit pointers; a pushed entry reaches the head one cycle later.
module simmem_resp_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [PtrW:0] wptr_q, rptr_q;
  T              mem_q [Depth];
  logic          push_en, pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign data_o  = mem_q[rptr_q[PtrW-1:0]];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + PtrOne;
      if (pop_en)  rptr_q <= rptr_q + PtrOne;
    end
  end

  // Storage is payload only; validity comes from the pointers.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/simmem_mem_responder.sv
// Behavioural far-end memory: counts write beats into responses, replays read
// bursts whose data is the beat address.
module simmem_mem_responder
  import simmem_pkg::*;
#(
  parameter int unsigned WAddrQueueDepth = simmem_pkg::WAddrQueueDepth,
  parameter int unsigned RAddrQueueDepth = simmem_pkg::RAddrQueueDepth
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  waddr_t waddr_i,
  input  logic   waddr_valid_i,
  output logic   waddr_ready_o,
  input  wdata_t wdata_i,
  input  logic   wdata_valid_i,
  output logic   wdata_ready_o,
  input  raddr_t raddr_i,
  input  logic   raddr_valid_i,
  output logic   raddr_ready_o,
  output wrsp_t  wrsp_o,
  output logic   wrsp_valid_o,
  input  logic   wrsp_ready_i,
  output rdata_t rdata_o,
  output logic   rdata_valid_o,
  input  logic   rdata_ready_i
);

  localparam logic [MaxBurstLenFieldW-1:0] CntOne = 1;

  waddr_t w_head;
  raddr_t r_head;
  logic   w_full, w_empty, r_full, r_empty;
  logic   w_push, w_hs, w_last;
  logic   r_push, r_pop, r_load;

  logic [MaxBurstLenFieldW-1:0] wcnt_q;
  wrsp_t                        wrsp_q;
  logic                         wrsp_valid_q;

  rd_state_e                    state_q, state_d;
  logic [IdW-1:0]               r_id_q;
  logic [AddrW-1:0]             r_addr_q;
  logic [MaxBurstLenFieldW-1:0] r_len_q, rcnt_q;
  logic                         r_last;

  simmem_resp_fifo #(.T(waddr_t), .Depth(WAddrQueueDepth)) u_wq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (waddr_i),
    .pop_i   (w_last),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  simmem_resp_fifo #(.T(raddr_t), .Depth(RAddrQueueDepth)) u_rq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (r_push),
    .data_i  (raddr_i),
    .pop_i   (r_pop),
    .data_o  (r_head),
    .full_o  (r_full),
    .empty_o (r_empty)
  );

  // Write path: beats only flow once their address is queued and no response is pending.
  assign waddr_ready_o = !w_full;
  assign w_push        = waddr_valid_i && waddr_ready_o;
  assign wdata_ready_o = !w_empty && !wrsp_valid_q;
  assign w_hs          = wdata_valid_i && wdata_ready_o;
  assign w_last        = w_hs && (wcnt_q == w_head.burst_len);
  assign wrsp_o        = wrsp_q;
  assign wrsp_valid_o  = wrsp_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q       <= '0;
      wrsp_q       <= '0;
      wrsp_valid_q <= 1'b0;
    end else if (w_hs) begin
      if (w_last) begin
        wcnt_q       <= '0;
        wrsp_q.id    <= w_head.id;
        wrsp_valid_q <= 1'b1;
      end else begin
        wcnt_q <= wcnt_q + CntOne;
      end
    end else if (wrsp_ready_i) begin
      wrsp_valid_q <= 1'b0;
    end
  end

  // Read path: reload straight from the queue on the last beat to avoid a bubble.
  assign raddr_ready_o = !r_full;
  assign r_push        = raddr_valid_i && raddr_ready_o;
  assign r_last        = (rcnt_q == r_len_q);

  always_comb begin
    state_d = state_q;
    r_pop   = 1'b0;
    r_load  = 1'b0;
    case (state_q)
      RdIdle: begin
        if (!r_empty) begin
          r_pop   = 1'b1;
          r_load  = 1'b1;
          state_d = RdBurst;
        end
      end
      RdBurst: begin
        if (rdata_ready_i && r_last) begin
          if (!r_empty) begin
            r_pop  = 1'b1;
            r_load = 1'b1;
          end else begin
            state_d = RdIdle;
          end
        end
      end
      default: state_d = RdIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RdIdle;
      r_id_q   <= '0;
      r_addr_q <= '0;
      r_len_q  <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (r_load) begin
        r_id_q   <= r_head.id;
        r_addr_q <= r_head.addr;
        r_len_q  <= r_head.burst_len;
        rcnt_q   <= '0;
      end else if (state_q == RdBurst && rdata_ready_i && !r_last) begin
        rcnt_q <= rcnt_q + CntOne;
      end
    end
  end

  assign rdata_valid_o = (state_q == RdBurst);

  always_comb begin
    rdata_o = '0;
    if (state_q == RdBurst) begin
      rdata_o.id   = r_id_q;
      rdata_o.data = DataW'(r_addr_q) + DataW'(rcnt_q);
      rdata_o.last = r_last;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{wdata_i, w_head.addr};

endmodule
